result_demux: RTL
=================

Name: result_demux

Overview:
- Buffered 1-to-NUM_OUT result router. It is the inverse of the datapath select mux: one 32-bit result stream in, steered to one of NUM_OUT destinations (e.g. regfile writeback, CSR unit, store-data path).
- A 2-entry FIFO decouples the producer from stalled consumers.
- Valid/ready handshake on every port.
- Out-of-range selects are dropped and counted.

Parameters:
- WIDTH, 32, data width.
- NUM_OUT, 3, number of destinations (2..2**SEL_W).
- SEL_W, 2, width of destination select.
- DEPTH, 2, FIFO entries (fixed at 2; the parameter is for documentation only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  block can accept.
- in_data  input  WIDTH  result value.
- in_sel  input  SEL_W  destination index.
- out_valid  output  NUM_OUT  one-hot, head entry offered to destination i.
- out_ready  input  NUM_OUT  destination i accepts.
- out_data  output  WIDTH  head entry data, shared by all destinations.
- drop_err  output  1  one-cycle pulse, out-of-range select discarded.
- drop_cnt  output  8  saturating count of discarded transfers.

Behaviour:
- Reset (rst=0, asynchronous): FIFO count=0, read/write pointers=0, out_valid=0, out_data=0, drop_err=0, drop_cnt=0. Reset mid-transfer discards all buffered entries; nothing is delivered after reset is released.
- Storage: 2 entries of {sel, data}; 1-bit write and read pointers that wrap 1->0; 2-bit count.
- in_ready = (count < 2), purely from registered state. There is no combinational path from in_valid or out_ready to in_ready.
- Push condition: in_valid & in_ready & (in_sel < NUM_OUT). The entry is written at wr_ptr, wr_ptr advances, and count increments.
- Drop condition: in_valid & in_ready & (in_sel >= NUM_OUT).
  - Entry is not stored.
  - drop_err=1 in the following cycle only.
  - drop_cnt increments and saturates at 255.
  - Back-to-back drops keep drop_err high.
- Head: when count>0, out_valid = one-hot of head.sel; out_data = head.data. When count=0, out_valid=0 and out_data=0.
- Pop condition: out_valid[h] & out_ready[h], where h = head.sel. rd_ptr advances and count decrements. out_ready bits for non-selected destinations are ignored.
- Latency: an entry accepted at edge N is offered at out_valid from edge N to N+1. Minimum in-to-out latency is 1 cycle; there is no combinational bypass.
- Throughput: a simultaneous push and pop with count=1 leaves count=1, which sustains 1 transfer/cycle.
- Full (count=2): in_ready=0, so no push. A pop in that cycle gives count=1, and in_ready rises the next cycle.
- Empty: a pop is impossible because out_valid=0.
- Ordering: strict FIFO across all destinations. A stalled head blocks later entries even if they target other destinations (no reordering).
- Stability: while out_valid[h]=1 and out_ready[h]=0, out_valid and out_data hold unchanged.
- Producer rule: in_data and in_sel are sampled only on an accepted edge. The producer holds them while in_valid=1 and in_ready=0.
- State summary (by count): EMPTY(0), ONE(1), FULL(2).
  - EMPTY->ONE on push.
  - ONE->FULL on push without pop.
  - ONE->EMPTY on pop without push.
  - FULL->ONE on pop.
  - All other combinations hold.

Test Plan:
1. Reset: drive rst=0 with in_valid=1, then release -> out_valid=0, in_ready=1, drop_cnt=0, out_data=0.
2. Single route: push data=32'h43392179, sel=2 with out_ready=3'b100 -> next cycle out_valid=3'b100, out_data=32'h43392179; popped; count returns to 0.
3. Backpressure/full: push 32'hD41202AB (sel 0) then 32'hB540ED3A (sel 1) with out_ready=0 -> in_ready=0 after the 2nd push. Third value 32'hEF0AE91D is held off. Raise out_ready[0] -> D41202AB delivered, then in_ready=1.
4. Streaming: out_ready=3'b111, 8 consecutive pushes with alternating sel 0/1/2 -> one delivery per cycle in order, in_ready continuously 1, 1-cycle latency.
5. Drop: push sel=3 data=32'hF9385D19 -> no out_valid, drop_err pulses for 1 cycle, drop_cnt=1. 300 more drops -> drop_cnt=255 (saturated).
6. Reset mid-operation: FIFO full with 2 entries, assert rst=0 for 1 cycle -> out_valid=0, count=0. The former entries never appear after release.

Source files
------------

// File: rtl/result_demux.sv
// Buffered 1-to-NUM_OUT result router: a 2-entry FIFO of {sel, data} whose head
// is offered to the destination named by its select; out-of-range selects are dropped.
module result_demux #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 3,
    parameter int SEL_W   = 2,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               drop_err,
    output logic [7:0]         drop_cnt,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and payload is stable while valid & !ready.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);

    state_t state;
    state_t state_nxt;
    entry_t mem [2];
    entry_t head;
    logic   wr_ptr;
    logic   rd_ptr;
    logic   has_head;
    logic   accept;
    logic   in_range;
    logic   push;
    logic   drop;
    logic   pop;

    assign dbg_state = state;
    assign in_ready  = ({30'b0, state} < 32'(DEPTH));
    assign in_range  = ({1'b0, in_sel} < NUM_OUT_W);
    assign accept    = in_valid & in_ready;
    assign push      = accept & in_range;
    assign drop      = accept & ~in_range;
    assign has_head  = (state != EMPTY);
    assign head      = mem[rd_ptr];
    assign out_data  = has_head ? head.data : '0;
    assign pop       = |(out_valid & out_ready);

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_valid[i] = has_head && (head.sel == SEL_W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE:     if (push && !pop) state_nxt = FULL;
                     else if (pop && !push) state_nxt = EMPTY;
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            drop_err <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{sel: in_sel, data: in_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            drop_err <= drop;
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
